// File: rtl/lsu_pkg.sv
// Shared state encoding, op constants and width defaults for the load/store unit.
package lsu_pkg;

  localparam int LSU_DATA_W = 16;
  localparam int LSU_ADDR_W = 16;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_addr_gen.sv
// Effective address adder (base + offset, wrapping) and, when LSU_ADDR_CHECK_EN
// is defined, the upper-limit fault compare.
module lsu_addr_gen #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = {ADDR_W{1'b1}}
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] off,
  output logic [ADDR_W-1:0] addr,
  output logic              fault
);

  // Sum is truncated to ADDR_W bits so the address silently wraps.
  assign addr = base + off;

`ifdef LSU_ADDR_CHECK_EN
  assign fault = (addr > ADDR_LIMIT);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer for the 16-bit word data memory: one request at a time,
// one-clock memory strobes, valid/ready response. Optional macro: LSU_ADDR_CHECK_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W = LSU_DATA_W,
  parameter int ADDR_W = LSU_ADDR_W,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_off,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] eff_addr;
  logic              eff_fault;
  logic              is_load_q, is_load_d;
  logic              fault_q, fault_d;
  logic              mem_en_d, mem_rd_d, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_d;
  logic              resp_err_d;

  lsu_addr_gen #(
    .ADDR_W    (ADDR_W),
    .ADDR_LIMIT(ADDR_LIMIT)
  ) u_addr_gen (
    .base (req_base),
    .off  (req_off),
    .addr (eff_addr),
    .fault(eff_fault)
  );

  assign req_ready = (state_q == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // A faulted request skips the memory and the read wait, like a store.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = ST_ACCESS;
      ST_ACCESS: state_d = (is_load_q && !fault_q) ? ST_WAIT : ST_RESP;
      ST_WAIT:   state_d = ST_RESP;
      ST_RESP:   if (resp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en_d     = 1'b0;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    resp_valid_d = resp_valid;
    resp_rdata_d = resp_rdata;
    resp_err_d   = resp_err;
    is_load_d    = is_load_q;
    fault_d      = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          mem_addr_d  = eff_addr;
          mem_wdata_d = req_wdata;
          is_load_d   = (req_we == OP_LOAD);
          fault_d     = eff_fault;
          mem_en_d    = !eff_fault;
          mem_rd_d    = !eff_fault && (req_we == OP_LOAD);
          mem_wr_d    = !eff_fault && (req_we == OP_STORE);
        end
      end
      ST_ACCESS: begin
        if (!is_load_q || fault_q) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          resp_err_d   = fault_q;
        end
      end
      ST_WAIT: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = mem_rdata;
        resp_err_d   = 1'b0;
      end
      ST_RESP: begin
        if (resp_ready) resp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en     <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      is_load_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      mem_en     <= mem_en_d;
      mem_rd     <= mem_rd_d;
      mem_wr     <= mem_wr_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
      is_load_q  <= is_load_d;
      fault_q    <= fault_d;
    end
  end

endmodule
